// File: rtl/fp_addsub_arbiter_if.sv
// Requester/response bundle for the shared fp_addsub arbiter.
// master: requesters + result consumer; slave: the arbiter.
interface fp_addsub_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_sub;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [31:0]          resp_result;

    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result
    );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin sequencer sharing one combinational fp_addsub unit.
// Ports: clk, rst_n; bus (requests/response); fpu_a/b/sub out,
// fpu_result in; busy (not IDLE); op_count (completed responses).
module fp_addsub_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_addsub_arbiter_if.slave   bus,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic                 fpu_sub,
    input  logic [31:0]          fpu_result,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   r_id;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_sub;
    logic [31:0]      r_res;
    logic             r_rv;
    logic             r_busy;
    logic [CNTW-1:0]  r_cnt;

    logic [IDW-1:0]   w_win;
    logic             w_any;
    logic [NREQ-1:0]  w_ready;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic             w_sel_sub;

    // Winner = valid requester at the smallest rotated distance
    // past the last granted index.
    always_comb begin : arb
        int d;
        int best;
        d     = 0;
        best  = NREQ;
        w_win = '0;
        w_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - 1 - int'(r_last)) % NREQ;
            if (bus.req_valid[i] && d < best) begin
                best  = d;
                w_win = IDW'(i);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        w_ready   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_sel_a   = bus.req_a[32*i +: 32];
                w_sel_b   = bus.req_b[32*i +: 32];
                w_sel_sub = bus.req_sub[i];
                w_ready[i] = w_any && (r_state == S_IDLE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= IDW'(NREQ - 1);
            r_grant <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_res   <= '0;
            r_rv    <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_sub   <= w_sel_sub;
                        r_grant <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res   <= fpu_result;
                    r_id    <= r_grant;
                    r_rv    <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_rv    <= 1'b0;
                        r_last  <= r_grant;
                        r_cnt   <= r_cnt + CNTW'(1);
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_rv    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.resp_valid  = r_rv;
    assign bus.resp_id     = r_id;
    assign bus.resp_result = r_res;
    assign fpu_a           = r_a;
    assign fpu_b           = r_b;
    assign fpu_sub         = r_sub;
    assign busy            = r_busy;
    assign op_count        = r_cnt;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: reference model + directed vectors.
// Shared fp unit modelled with real arithmetic on exact values.
module tb_fp_addsub_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fpu_a, fpu_b, fpu_result;
    logic        fpu_sub, busy;
    logic [15:0] op_count;

    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic        op_s [4];

    int n_cmp = 0;
    int n_fail = 0;
    int dut_grants[$];

    // reference model state
    int          m_phase = 0;
    int          m_last = 3;
    int          m_grant = 0;
    int          m_id = 0;
    int          m_cnt = 0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic        m_sub = 1'b0;

    fp_addsub_arbiter_if #(.NREQ(4)) bus ();

    fp_addsub_arbiter #(.NREQ(4), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sub(fpu_sub),
        .fpu_result(fpu_result), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic real s2r(logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return 0.0;
        e = {3'b0, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] f_addsub(logic [31:0] a, logic [31:0] b, logic s);
        return s ? r2s(s2r(a) - s2r(b)) : r2s(s2r(a) + s2r(b));
    endfunction

    assign fpu_result = f_addsub(fpu_a, fpu_b, fpu_sub);
    assign bus.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign bus.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
    assign bus.req_sub = {op_s[3], op_s[2], op_s[1], op_s[0]};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // rotation search from last+1 with wrap
    function automatic int m_pick(logic [3:0] v, int last);
        logic [3:0] t;
        for (int k = 1; k <= 4; k++) begin
            t = v >> ((last + k) % 4);
            if (t[0]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // compare process: outputs vs model every negedge, then advance model
    initial begin
        logic [3:0] acc;
        logic [3:0] t;
        int w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0; m_last = 3; m_grant = 0; m_id = 0; m_cnt = 0;
                m_a = '0; m_b = '0; m_res = '0; m_sub = 1'b0;
            end
            w = (m_phase == 0) ? m_pick(bus.req_valid, m_last) : -1;
            chk("req_ready", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
            chk("onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            chk("resp_valid", 32'(bus.resp_valid), 32'(m_phase == 2));
            chk("resp_id", 32'(bus.resp_id), 32'(m_id));
            chk("resp_result", bus.resp_result, m_res);
            chk("fpu_a", fpu_a, m_a);
            chk("fpu_b", fpu_b, m_b);
            chk("fpu_sub", 32'(fpu_sub), 32'(m_sub));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("op_count", 32'(op_count), 32'(m_cnt % 65536));
            if (rst_n) begin
                acc = bus.req_valid & bus.req_ready;
                for (int i = 0; i < 4; i++)
                    if (acc[i]) dut_grants.push_back(i);
                case (m_phase)
                    0: if (w >= 0) begin
                        m_grant = w;
                        m_a = 32'(bus.req_a >> (32 * w));
                        m_b = 32'(bus.req_b >> (32 * w));
                        t = bus.req_sub >> w;
                        m_sub = t[0];
                        m_phase = 1;
                    end
                    1: begin
                        m_res = f_addsub(m_a, m_b, m_sub);
                        m_id = m_grant;
                        m_phase = 2;
                    end
                    default: if (bus.resp_ready) begin
                        m_last = m_grant;
                        m_cnt++;
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(int max);
        int n = 0;
        while (busy && n < max) begin step(1); n++; end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic wait_rv(int max);
        int n = 0;
        while (!bus.resp_valid && n < max) begin step(1); n++; end
        chk("resp_wait", 32'(bus.resp_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp3[6] = '{0, 1, 2, 3, 0, 1};
        int exp5[3] = '{0, 3, 0};
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_s[i] = 1'b0;
        end
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        step(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;

        // single add on requester 0
        op_a[0] = 32'h3F800000; op_b[0] = 32'h40000000; op_s[0] = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'h1);
        step(1);
        bus.req_valid = '0;
        chk("t1_exec_rv", 32'(bus.resp_valid), 32'd0);
        chk("t1_fpu_a", fpu_a, 32'h3F800000);
        step(1);
        chk("t1_rv", 32'(bus.resp_valid), 32'd1);
        chk("t1_id", 32'(bus.resp_id), 32'd0);
        chk("t1_res", bus.resp_result, 32'h40400000);
        step(1);
        chk("t1_count", 32'(op_count), 32'd1);

        // subtract on requester 2
        op_a[2] = 32'h40400000; op_b[2] = 32'h3F800000; op_s[2] = 1'b1;
        bus.req_valid = 4'b0100;
        step(1);
        bus.req_valid = '0;
        chk("t2_fpu_sub", 32'(fpu_sub), 32'd1);
        step(1);
        chk("t2_id", 32'(bus.resp_id), 32'd2);
        chk("t2_res", bus.resp_result, 32'h40000000);
        wait_idle(5);

        // all four valid, strict rotation from reset
        do_reset();
        dut_grants.delete();
        op_a[0] = 32'h3F800000; op_a[1] = 32'h40000000;
        op_a[2] = 32'h40400000; op_a[3] = 32'h40800000;
        for (int i = 0; i < 4; i++) begin
            op_b[i] = 32'h3F000000;
            op_s[i] = (i % 2) == 1;
        end
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 60 && dut_grants.size() < 6; n++) step(1);
        bus.req_valid = '0;
        wait_idle(5);
        chk("t3_count", 32'(op_count), 32'd6);
        chk("t3_ngrant", 32'(dut_grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < dut_grants.size(); i++)
            chk($sformatf("t3_grant%0d", i), 32'(dut_grants[i]), 32'(exp3[i]));

        // backpressure: hold response for 5 cycles
        bus.resp_ready = 1'b0;
        op_a[1] = 32'h40800000; op_b[1] = 32'h40400000; op_s[1] = 1'b1;
        bus.req_valid = 4'b0010;
        step(1);
        bus.req_valid = 4'b0001;
        wait_rv(5);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_hold_rv", 32'(bus.resp_valid), 32'd1);
            chk("t4_hold_id", 32'(bus.resp_id), 32'd1);
            chk("t4_hold_res", bus.resp_result, 32'h3F800000);
            chk("t4_hold_busy", 32'(busy), 32'd1);
            chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        bus.req_valid = '0;
        step(1);
        chk("t4_rel_busy", 32'(busy), 32'd0);
        chk("t4_rel_rv", 32'(bus.resp_valid), 32'd0);

        // withdrawn request on requester 1
        dut_grants.delete();
        op_a[0] = 32'h3F800000; op_b[0] = 32'h3F800000; op_s[0] = 1'b0;
        bus.req_valid = 4'b0001;
        step(1);
        bus.req_valid = 4'b0010;
        step(1);
        bus.req_valid = 4'b1000;
        step(2);
        bus.req_valid = '0;
        wait_idle(5);
        bus.req_valid = 4'b1111;
        step(1);
        bus.req_valid = '0;
        wait_idle(5);
        chk("t5_ngrant", 32'(dut_grants.size()), 32'd3);
        for (int i = 0; i < 3 && i < dut_grants.size(); i++)
            chk($sformatf("t5_grant%0d", i), 32'(dut_grants[i]), 32'(exp5[i]));

        // reset while executing
        bus.req_valid = 4'b0100;
        step(1);
        bus.req_valid = '0;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rv", 32'(bus.resp_valid), 32'd0);
        chk("t6_fpu_a", fpu_a, 32'd0);
        chk("t6_fpu_sub", 32'(fpu_sub), 32'd0);
        chk("t6_count", 32'(op_count), 32'd0);
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t6_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        dut_grants.delete();
        bus.req_valid = 4'b1111;
        step(1);
        bus.req_valid = '0;
        chk("t6_ngrant", 32'(dut_grants.size()), 32'd1);
        if (dut_grants.size() > 0)
            chk("t6_grant0", 32'(dut_grants[0]), 32'd0);
        wait_idle(5);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational fp_addsub unit between NREQ requesters.
- Each requester presents two IEEE-754 single-precision operands and an add/sub select over a valid/ready handshake.
- The block issues one request to the shared unit, captures the result, and returns it tagged with the requester index.
- Sits between the byte-serial front ends / host-side loaders and the single shared fp_addsub instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of requester index (derived localparam, not overridable).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  32*NREQ  operand A; requester i in bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing.
- req_sub  in  NREQ  1 = subtract (A-B), 0 = add.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_result  out  32  result word.
- fpu_a  out  32  to shared unit operand A.
- fpu_b  out  32  to shared unit operand B.
- fpu_sub  out  1  to shared unit sub select.
- fpu_result  in  32  from shared unit (combinational from fpu_a/b/sub).
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNTW  completed responses since reset.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_result=0, fpu_a=0, fpu_b=0, fpu_sub=0, busy=0, op_count=0; last_grant=NREQ-1, so requester 0 has first priority.
- IDLE, arbitration: the winner is the first i with req_valid[i]=1, scanning from last_grant+1 upward with wrap modulo NREQ.
- req_ready is combinational: only req_ready[winner] is high, only in IDLE, only while req_valid[winner] is high.
- Accept in IDLE: on req_valid[i] & req_ready[i], latch req_a/req_b/req_sub slice i into the operand registers, latch grant=i, go to EXEC.
- IDLE with no valid request: stay in IDLE, all req_ready=0.
- fpu_a/fpu_b/fpu_sub are driven from the operand registers at all times (registered outputs, no combinational path from req_*).
- EXEC, one cycle: capture fpu_result into resp_result, set resp_id=grant, set resp_valid=1, go to RESP.
- RESP: hold resp_valid/resp_id/resp_result stable until resp_ready=1.
- On the RESP handshake: resp_valid->0 next cycle, last_grant<=grant, op_count+=1 (wraps at 2^CNTW, no saturation), return to IDLE.
- Latency: accept edge -> resp_valid high 2 cycles later. Minimum issue interval 3 cycles. No new request is accepted while busy.
- Fairness: a requester holding valid is granted within NREQ arbitration rounds.
- A requester that drops valid before acceptance loses nothing: no grant is consumed and last_grant is unchanged.
- All requests valid simultaneously: grant order is strict rotation, e.g. 0,1,2,3,0,...
- resp_ready high while resp_valid low: ignored.
- Reset asserted mid-operation: the in-flight request is discarded with no response, the FSM returns to IDLE, and all reset values apply immediately (asynchronous).
- The requester must hold its operands stable only until the accept edge.

Test Plan:
- Single add: req0 a=0x3F800000, b=0x40000000, sub=0 -> req_ready[0] high that cycle; 2 cycles later resp_valid=1, resp_id=0, resp_result=0x40400000; op_count=1 after handshake.
- Subtract on req2 only: a=0x40400000, b=0x3F800000, sub=1 -> resp_id=2, resp_result=0x40000000; fpu_sub=1 during EXEC.
- All 4 valid continuously, resp_ready tied high -> grants 0,1,2,3,0,1 at 3-cycle spacing; never two req_ready bits high; op_count=6.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid/resp_id/resp_result held constant, busy=1, no req_ready asserted; release -> IDLE next cycle.
- Withdrawn request: req1 valid one cycle while busy, then deasserted; req3 valid -> req3 granted, req1 never acknowledged, last_grant=3.
- Reset in EXEC: assert rst_n=0 -> outputs at reset values immediately, no resp_valid after release, next grant goes to requester 0.
